// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder.
//   stateT      : responder FSM state encoding (IDLE / WAIT / DONE)
//   WORD_BYTES  : bytes per RAM word
//   WEN_*       : byte-lane write-enable patterns with special meaning
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } stateT;

  localparam int WORD_BYTES = 4;

  localparam logic [3:0] WEN_READ    = 4'b0000;
  localparam logic [3:0] WEN_WORD    = 4'b1111;
  localparam logic [3:0] WEN_HALF_LO = 4'b0011;
  localparam logic [3:0] WEN_HALF_HI = 4'b1100;

endpackage

// File: rtl/dmem_responder_if.sv
// Core <-> responder data-memory bus.
//   mem_en : request valid              (core -> responder)
//   wen    : byte-lane write enables    (core -> responder), 0 = read
//   addr   : byte address               (core -> responder)
//   wdata  : lane-aligned write data    (core -> responder)
//   rdata  : registered read data       (responder -> core)
//   stall  : hold request stable        (responder -> core)
//   err    : dropped-access pulse       (responder -> core)
// master = core side, slave = responder side.
interface dmem_responder_if;

  logic        mem_en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        err;

  modport master (
    output mem_en, wen, addr, wdata,
    input  rdata, stall, err
  );

  modport slave (
    input  mem_en, wen, addr, wdata,
    output rdata, stall, err
  );

endinterface

// File: rtl/dmem_responder_byte_ram.sv
// dmem_byte_ram: 4-lane synchronous RAM, one port.
//   clk   : clock
//   ce    : port enable; nothing happens when low
//   we    : per-lane write enables, all-zero selects a read
//   addr  : word index
//   wdata : write data, lane i in bits 8*i+7 : 8*i
//   q     : registered read data, updated only by reads
// Contents and q are not reset.
module dmem_byte_ram
  import dmem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  ce,
  input  logic [3:0]            we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           q
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [WORD_BYTES-1:0][7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (ce) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (we[i]) mem[addr][i] <= wdata[8*i +: 8];
      end
      if (we == WEN_READ) q <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: responder side of the core's data-memory port.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : dmem_responder_if.slave (mem_en/wen/addr/wdata in, rdata/stall/err out)
// An access completes on the edge ending the first cycle with mem_en=1 and
// stall=0. With WAIT_CYCLES>0 each request is stalled for exactly WAIT_CYCLES
// cycles, then performed in DONE. Misaligned or out-of-range accesses are
// dropped, force rdata to zero and pulse err for one cycle.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus
);

  localparam int          CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [32:0] SPAN     = 33'(WORD_BYTES) << ADDR_WIDTH;

  stateT                 state;
  logic [CNT_W-1:0]      cnt;
  logic                  useRam;
  logic                  errQ;

  logic [31:0]           offset;
  logic                  inRange;
  logic                  misaligned;
  logic                  accErr;
  logic                  isRead;
  logic                  complete;
  logic                  ramCe;
  logic [ADDR_WIDTH-1:0] wordIdx;
  logic [31:0]           ramQ;

  // BASE_ADDR is word aligned, so offset[1:0] equals addr[1:0]. Addresses below
  // the base wrap to huge offsets and fail the range test.
  assign offset  = bus.addr - BASE_ADDR;
  assign inRange = {1'b0, offset} < SPAN;
  assign wordIdx = offset[ADDR_WIDTH+1:2];

  assign misaligned =
    (((bus.wen == WEN_READ) || (bus.wen == WEN_WORD)) && (offset[1:0] != 2'b00)) ||
    (((bus.wen == WEN_HALF_LO) || (bus.wen == WEN_HALF_HI)) && offset[0]);

  assign accErr = !inRange || misaligned;
  assign isRead = (bus.wen == WEN_READ);

  // rst gates the port so a request held during reset never touches the RAM.
  assign complete = !rst && bus.mem_en &&
                    ((state == DONE) || ((state == IDLE) && (WAIT_CYCLES == 0)));
  assign ramCe    = complete && !accErr;

  assign bus.stall = !rst &&
                     ((state == WAIT) ||
                      ((state == IDLE) && bus.mem_en && (WAIT_CYCLES != 0)));

  // rdata is zero after reset or a dropped access, else the last RAM read.
  assign bus.rdata = useRam ? ramQ : 32'h0;
  assign bus.err   = errQ;

  // The IDLE request cycle is itself the first stall cycle, so WAIT leaves one
  // step early (at cnt==1) and WAIT_CYCLES=1 skips WAIT entirely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      useRam <= 1'b0;
      errQ   <= 1'b0;
    end else begin
      errQ <= complete && accErr;
      if (complete) begin
        if (accErr)      useRam <= 1'b0;
        else if (isRead) useRam <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (bus.mem_en && (WAIT_CYCLES != 0)) begin
            cnt   <= CNT_LOAD;
            state <= (CNT_LOAD == '0) ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (!bus.mem_en) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  dmem_byte_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) uRam (
    .clk  (clk),
    .ce   (ramCe),
    .we   (bus.wen),
    .addr (wordIdx),
    .wdata(bus.wdata),
    .q    (ramQ)
  );

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst0;
  logic rst2;

  always #5 clk = ~clk;

  dmem_responder_if bus0 ();
  dmem_responder_if bus2 ();

  dmem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst0), .bus(bus0.slave)
  );

  dmem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst2), .bus(bus2.slave)
  );

  int passCnt  = 0;
  int checkCnt = 0;
  int hits2    = 0;

  always @(posedge clk) if (dut2.uRam.ce) hits2 <= hits2 + 1;

  // Reference model: byte-addressed memory image plus expected outputs.
  logic [7:0]  mb [2][4096];
  logic [31:0] expRd [2];
  logic        expErr [2];

  function automatic bit modelErr(input logic [3:0] w, input logic [31:0] a);
    bit bad;
    bad = (a >= 32'h0000_1000);
    if ((w == 4'h0 || w == 4'hF) && (a[1:0] != 2'b00)) bad = 1'b1;
    if ((w == 4'h3 || w == 4'hC) && a[0]) bad = 1'b1;
    return bad;
  endfunction

  task automatic modelAcc(input int k, input logic [3:0] w, input logic [31:0] a,
                          input logic [31:0] d);
    int b;
    b = int'(a & 32'h0000_0FFC);
    expErr[k] = modelErr(w, a);
    if (expErr[k]) expRd[k] = 32'h0;
    else if (w == 4'h0) expRd[k] = {mb[k][b+3], mb[k][b+2], mb[k][b+1], mb[k][b]};
    else for (int i = 0; i < 4; i++) if (w[i]) mb[k][b+i] = d[8*i +: 8];
  endtask

  task automatic modelReset(input int k);
    expRd[k]  = 32'h0;
    expErr[k] = 1'b0;
  endtask

  // Drivers are entered just after a rising edge and return just after the
  // completing edge.
  task automatic drive0(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic e, output logic st);
    bus0.mem_en = 1'b1; bus0.wen = w; bus0.addr = a; bus0.wdata = d;
    @(negedge clk);
    st = bus0.stall;
    @(posedge clk); #1;
    rd = bus0.rdata;
    e  = bus0.err;
    bus0.mem_en = 1'b0;
  endtask

  task automatic drive2(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic e, output int nStall,
                        output bit timeout);
    logic s;
    bus2.mem_en = 1'b1; bus2.wen = w; bus2.addr = a; bus2.wdata = d;
    nStall  = 0;
    timeout = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      s = bus2.stall;
      @(posedge clk); #1;
      if (s) nStall++;
      else begin
        timeout = 1'b0;
        break;
      end
    end
    rd = bus2.rdata;
    e  = bus2.err;
    bus2.mem_en = 1'b0;
  endtask

  task automatic initRegion();
    logic [31:0] rd, d; logic e, st; int n; bit to;
    for (int i = 0; i < 64; i++) begin
      d = $urandom() | 32'h0100_0001;
      drive0(4'hF, 32'(i * 4), d, rd, e, st);
      modelAcc(0, 4'hF, 32'(i * 4), d);
      drive2(4'hF, 32'(i * 4), d, rd, e, n, to);
      modelAcc(1, 4'hF, 32'(i * 4), d);
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic e, st; int n; bit to;
    drive0(4'h0, 32'h10, 32'h0, rd, e, st);
    modelAcc(0, 4'h0, 32'h10, 32'h0);
    rst0 = 1'b1; rst2 = 1'b1;
    bus0.mem_en = 1'b1; bus0.wen = 4'hF; bus0.addr = 32'h10; bus0.wdata = 32'h9999_9999;
    bus2.mem_en = 1'b1; bus2.wen = 4'hF; bus2.addr = 32'h10; bus2.wdata = 32'h9999_9999;
    repeat (3) begin
      @(negedge clk);
      checkCnt++;
      if ({bus0.rdata, bus0.stall, bus0.err} !== 34'h0)
        $display("FAIL reset0: rdata=%h stall=%b err=%b want 0/0/0", bus0.rdata, bus0.stall, bus0.err);
      else passCnt++;
      checkCnt++;
      if ({bus2.rdata, bus2.stall, bus2.err} !== 34'h0)
        $display("FAIL reset2: rdata=%h stall=%b err=%b want 0/0/0", bus2.rdata, bus2.stall, bus2.err);
      else passCnt++;
    end
    bus0.mem_en = 1'b0; bus2.mem_en = 1'b0;
    @(posedge clk); #1;
    rst0 = 1'b0; rst2 = 1'b0;
    modelReset(0); modelReset(1);
    drive0(4'h0, 32'h10, 32'h0, rd, e, st);
    modelAcc(0, 4'h0, 32'h10, 32'h0);
    checkCnt++;
    if (rd !== expRd[0]) $display("FAIL reset_nowrite0: got %h want %h", rd, expRd[0]);
    else passCnt++;
    drive2(4'h0, 32'h10, 32'h0, rd, e, n, to);
    modelAcc(1, 4'h0, 32'h10, 32'h0);
    checkCnt++;
    if (rd !== expRd[1]) $display("FAIL reset_nowrite2: got %h want %h", rd, expRd[1]);
    else passCnt++;
  endtask

  task automatic test_write_read();
    logic [31:0] rd, held; logic e, st1, st2;
    held = expRd[0];
    drive0(4'hF, 32'h10, 32'hDEAD_BEEF, rd, e, st1);
    modelAcc(0, 4'hF, 32'h10, 32'hDEAD_BEEF);
    checkCnt++;
    if (rd !== held || e !== 1'b0)
      $display("FAIL wr_hold: rdata=%h err=%b want %h/0", rd, e, held);
    else passCnt++;
    drive0(4'h0, 32'h10, 32'h0, rd, e, st2);
    modelAcc(0, 4'h0, 32'h10, 32'h0);
    checkCnt++;
    if (rd !== 32'hDEAD_BEEF || e !== 1'b0 || st1 !== 1'b0 || st2 !== 1'b0)
      $display("FAIL wr_rd: rdata=%h err=%b stall=%b%b want deadbeef/0/00", rd, e, st1, st2);
    else passCnt++;
    @(posedge clk); #1;
    checkCnt++;
    if (bus0.rdata !== 32'hDEAD_BEEF)
      $display("FAIL idle_hold: got %h want deadbeef", bus0.rdata);
    else passCnt++;
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; logic e, st;
    logic [3:0]  wl [3] = '{4'h1, 4'h8, 4'hC};
    logic [31:0] al [3] = '{32'h10, 32'h10, 32'h12};
    logic [31:0] dl [3] = '{32'h0000_00AA, 32'hBB00_0000, 32'h1234_0000};
    logic [31:0] xl [3] = '{32'hDEAD_BEAA, 32'hBBAD_BEAA, 32'h1234_BEAA};
    for (int i = 0; i < 3; i++) begin
      drive0(wl[i], al[i], dl[i], rd, e, st);
      modelAcc(0, wl[i], al[i], dl[i]);
      drive0(4'h0, 32'h10, 32'h0, rd, e, st);
      modelAcc(0, 4'h0, 32'h10, 32'h0);
      checkCnt++;
      if (rd !== xl[i] || e !== 1'b0)
        $display("FAIL lanes%0d: rdata=%h err=%b want %h/0", i, rd, e, xl[i]);
      else passCnt++;
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic e, st;
    drive0(4'h0, 32'h12, 32'h0, rd, e, st);
    checkCnt++;
    if (rd !== 32'h0 || e !== 1'b1)
      $display("FAIL err_misread: rdata=%h err=%b want 0/1", rd, e);
    else passCnt++;
    @(posedge clk); #1;
    checkCnt++;
    if (bus0.err !== 1'b0) $display("FAIL err_pulse: err=%b want 0", bus0.err);
    else passCnt++;
    drive0(4'hF, 32'h0, 32'hA5A5_0F0F, rd, e, st);
    modelAcc(0, 4'hF, 32'h0, 32'hA5A5_0F0F);
    drive0(4'hF, 32'h1000, 32'h5555_5555, rd, e, st);
    checkCnt++;
    if (e !== 1'b1) $display("FAIL err_range: err=%b want 1", e);
    else passCnt++;
    drive0(4'h0, 32'h0, 32'h0, rd, e, st);
    checkCnt++;
    if (rd !== 32'hA5A5_0F0F || e !== 1'b0)
      $display("FAIL err_nowrap: rdata=%h err=%b want a5a50f0f/0", rd, e);
    else passCnt++;
    drive0(4'h3, 32'h11, 32'hFFFF_FFFF, rd, e, st);
    checkCnt++;
    if (e !== 1'b1 || rd !== 32'h0) $display("FAIL err_half: rdata=%h err=%b want 0/1", rd, e);
    else passCnt++;
    drive0(4'h3, 32'h12, 32'h0000_7777, rd, e, st);
    modelAcc(0, 4'h3, 32'h12, 32'h0000_7777);
    checkCnt++;
    if (e !== 1'b0) $display("FAIL half_ok: err=%b want 0", e);
    else passCnt++;
    drive0(4'h0, 32'h10, 32'h0, rd, e, st);
    checkCnt++;
    if (rd !== 32'h1234_7777) $display("FAIL half_data: got %h want 12347777", rd);
    else passCnt++;
    modelAcc(0, 4'h0, 32'h10, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, d [8]; logic e, st; longint t0; int bad;
    bad = 0;
    t0 = $time;
    for (int i = 0; i < 8; i++) begin
      d[i] = $urandom();
      drive0(4'hF, 32'(32'h40 + i * 4), d[i], rd, e, st);
      modelAcc(0, 4'hF, 32'(32'h40 + i * 4), d[i]);
      if (st !== 1'b0) bad++;
    end
    for (int i = 0; i < 8; i++) begin
      drive0(4'h0, 32'(32'h40 + i * 4), 32'h0, rd, e, st);
      modelAcc(0, 4'h0, 32'(32'h40 + i * 4), 32'h0);
      checkCnt++;
      if (rd !== d[i] || e !== 1'b0)
        $display("FAIL b2b_rd%0d: rdata=%h err=%b want %h/0", i, rd, e, d[i]);
      else passCnt++;
      if (st !== 1'b0) bad++;
    end
    checkCnt++;
    if (($time - t0) / 10 != 16 || bad != 0)
      $display("FAIL b2b_rate: cycles=%0d stalls=%0d want 16/0", ($time - t0) / 10, bad);
    else passCnt++;
  endtask

  task automatic test_random();
    logic [31:0] rd, a, d; logic [3:0] w; logic e, st; int r;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      w = (r < 4) ? 4'h0 : (r < 6) ? 4'hF : (r < 8) ? 4'($urandom()) : (r == 8) ? 4'h3 : 4'hC;
      a = 32'($urandom_range(0, 63) * 4);
      if ($urandom_range(0, 5) == 0) a = a + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) a = 32'h1000 + ($urandom() % 32'hFFFF_F000);
      d = $urandom();
      drive0(w, a, d, rd, e, st);
      modelAcc(0, w, a, d);
      checkCnt++;
      if (rd !== expRd[0] || e !== expErr[0] || st !== 1'b0)
        $display("FAIL rand0 #%0d wen=%h addr=%h: rdata=%h err=%b stall=%b want %h/%b/0",
                 i, w, a, rd, e, st, expRd[0], expErr[0]);
      else passCnt++;
    end
  endtask

  task automatic test_wait();
    logic [31:0] rd; logic e; int n, h0; bit to;
    drive2(4'hF, 32'h10, 32'hDEAD_BEEF, rd, e, n, to);
    modelAcc(1, 4'hF, 32'h10, 32'hDEAD_BEEF);
    h0 = hits2;
    drive2(4'h0, 32'h10, 32'h0, rd, e, n, to);
    modelAcc(1, 4'h0, 32'h10, 32'h0);
    checkCnt++;
    if (to || n != 2) $display("FAIL wait_stall: stall cycles=%0d timeout=%b want 2/0", n, to);
    else passCnt++;
    checkCnt++;
    if (rd !== 32'hDEAD_BEEF || e !== 1'b0)
      $display("FAIL wait_rd: rdata=%h err=%b want deadbeef/0", rd, e);
    else passCnt++;
    @(negedge clk);
    checkCnt++;
    if (hits2 - h0 != 1 || bus2.stall !== 1'b0)
      $display("FAIL wait_hits: hits=%0d stall=%b want 1/0", hits2 - h0, bus2.stall);
    else passCnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_wait_abort();
    logic [31:0] rd, held; logic e; int n; bit to;
    held = bus2.rdata;
    bus2.mem_en = 1'b1; bus2.wen = 4'hF; bus2.addr = 32'h24; bus2.wdata = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    bus2.mem_en = 1'b0;
    @(posedge clk); #1;
    checkCnt++;
    if (bus2.err !== 1'b0 || bus2.stall !== 1'b0 || bus2.rdata !== held)
      $display("FAIL abort: err=%b stall=%b rdata=%h want 0/0/%h", bus2.err, bus2.stall, bus2.rdata, held);
    else passCnt++;
    drive2(4'h0, 32'h24, 32'h0, rd, e, n, to);
    modelAcc(1, 4'h0, 32'h24, 32'h0);
    checkCnt++;
    if (rd !== expRd[1] || to) $display("FAIL abort_nowrite: got %h want %h", rd, expRd[1]);
    else passCnt++;
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd; logic e; int n; bit to;
    drive2(4'hF, 32'h20, 32'hCAFE_F00D, rd, e, n, to);
    modelAcc(1, 4'hF, 32'h20, 32'hCAFE_F00D);
    bus2.mem_en = 1'b1; bus2.wen = 4'hF; bus2.addr = 32'h20; bus2.wdata = 32'h1234_5678;
    @(posedge clk); #2;
    checkCnt++;
    if (bus2.stall !== 1'b1) $display("FAIL midwait_pre: stall=%b want 1", bus2.stall);
    else passCnt++;
    rst2 = 1'b1;
    #1;
    checkCnt++;
    if (bus2.stall !== 1'b0 || bus2.rdata !== 32'h0 || bus2.err !== 1'b0)
      $display("FAIL midwait_rst: stall=%b rdata=%h err=%b want 0/0/0", bus2.stall, bus2.rdata, bus2.err);
    else passCnt++;
    @(posedge clk); #1;
    bus2.mem_en = 1'b0;
    rst2 = 1'b0;
    modelReset(1);
    drive2(4'h0, 32'h20, 32'h0, rd, e, n, to);
    modelAcc(1, 4'h0, 32'h20, 32'h0);
    checkCnt++;
    if (rd !== 32'hCAFE_F00D || e !== 1'b0 || to)
      $display("FAIL midwait_data: rdata=%h err=%b want cafef00d/0", rd, e);
    else passCnt++;
  endtask

  task automatic test_random_wait();
    logic [31:0] rd, a, d; logic [3:0] w; logic e; int n, r; bit to;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 5);
      w = (r < 3) ? 4'h0 : (r < 5) ? 4'hF : 4'($urandom());
      a = 32'($urandom_range(0, 63) * 4);
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      d = $urandom();
      drive2(w, a, d, rd, e, n, to);
      modelAcc(1, w, a, d);
      checkCnt++;
      if (rd !== expRd[1] || e !== expErr[1] || n != 2 || to)
        $display("FAIL rand2 #%0d wen=%h addr=%h: rdata=%h err=%b stalls=%0d want %h/%b/2",
                 i, w, a, rd, e, n, expRd[1], expErr[1]);
      else passCnt++;
    end
  endtask

  initial begin
    bus0.mem_en = 1'b0; bus0.wen = 4'h0; bus0.addr = 32'h0; bus0.wdata = 32'h0;
    bus2.mem_en = 1'b0; bus2.wen = 4'h0; bus2.addr = 32'h0; bus2.wdata = 32'h0;
    rst0 = 1'b1; rst2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst0 = 1'b0; rst2 = 1'b0;
    modelReset(0); modelReset(1);
    initRegion();
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_errors();
    test_back_to_back();
    test_random();
    test_wait();
    test_wait_abort();
    test_reset_mid_wait();
    test_random_wait();
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
